// File: rtl/comms_pkg.sv
// Link constants and shared types for the comms transmitter/receiver pair.
package comms_pkg;

    localparam int COMMS_FRAME_WIDTH  = 256;
    localparam int COMMS_SYNC_STAGES  = 2;
    localparam int COMMS_IDLE_TIMEOUT = 64;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/comms_sync.sv
// Retimes the serial link clkIn/dataIn into clk with equal-depth chains and flags clkIn rising edges.
module comms_sync
    import comms_pkg::*;
#(
    parameter int SYNC_STAGES = COMMS_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_in_i,
    input  logic data_in_i,
    output logic rx_edge_o,
    output logic rx_bit_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   clk_hist_q;
    logic                   sync_valid;

    // The chains carry reset zeros, not pin samples, until fill_q has walked through.
    assign sync_valid = fill_q[SYNC_STAGES-1];

    // NOTE: every stage uses <= so each flop samples its neighbour's pre-edge value; blocking
    // assignments here would collapse the chain into a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            fill_q      <= '0;
            clk_hist_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], clk_in_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_in_i};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            if (sync_valid) begin
                clk_hist_q <= clk_sync_q[SYNC_STAGES-1];
            end
        end
    end

    assign rx_edge_o = sync_valid & clk_sync_q[SYNC_STAGES-1] & ~clk_hist_q;
    assign rx_bit_o  = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/comms_receiver.sv
// Receive end of the serial comms link: bit assembly and double-buffered frame hand-off.
// Defining COMMS_RX_TIMEOUT_EN adds the mid-frame idle abort that drives frameError.
module comms_receiver
    import comms_pkg::*;
#(
    parameter int WIDTH        = COMMS_FRAME_WIDTH,
    parameter int SYNC_STAGES  = COMMS_SYNC_STAGES
`ifdef COMMS_RX_TIMEOUT_EN
    ,
    parameter int IDLE_TIMEOUT = COMMS_IDLE_TIMEOUT
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkIn,
    input  logic             dataIn,
    input  logic             dataAck,
    output logic [WIDTH-1:0] receiveBuffer,
    output logic             newData,
    output logic             readyForReceive,
    output logic             overrun,
    output logic             frameError
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic             rx_edge;
    logic             rx_bit;
    logic             frame_done;
    logic             timeout;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] frame;
    logic [WIDTH-1:0] hold_q, hold_d;
    buf_state_e       state_q, state_d;
    logic             overrun_q, overrun_d;

    comms_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .clk_in_i (clkIn),
        .data_in_i(dataIn),
        .rx_edge_o(rx_edge),
        .rx_bit_o (rx_bit)
    );

    assign frame_done = rx_edge && (bit_cnt_q == LAST_BIT);

    // The final bit bypasses the shift register so the holding register loads in the same cycle.
    always_comb begin
        frame          = shift_q;
        frame[WIDTH-1] = rx_bit;
    end

`ifdef COMMS_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              frame_error_q;

    always_comb begin
        idle_d  = '0;
        timeout = 1'b0;
        if (!rx_edge && (bit_cnt_q != '0)) begin
            if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                timeout = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q        <= '0;
            frame_error_q <= 1'b0;
        end else begin
            idle_q        <= idle_d;
            frame_error_q <= timeout;
        end
    end

    assign frameError = frame_error_q;
`else
    assign timeout    = 1'b0;
    assign frameError = 1'b0;
`endif

    // NOTE: every _d takes its hold value before any branch; a path that skipped an assignment
    // would turn this block into a latch.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        state_d   = state_q;
        overrun_d = overrun_q;

        if (rx_edge) begin
            shift_d[bit_cnt_q] = rx_bit;
            bit_cnt_d          = frame_done ? '0 : bit_cnt_q + 1'b1;
        end else if (timeout) begin
            bit_cnt_d = '0;
        end

        case (state_q)
            BUF_EMPTY: begin
                if (frame_done) begin
                    hold_d  = frame;
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (frame_done && dataAck) begin
                    hold_d = frame;
                end else if (frame_done) begin
                    overrun_d = 1'b1;
                end else if (dataAck) begin
                    state_d = BUF_EMPTY;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // NOTE: the wide shift and holding registers are reset explicitly because their zero
    // state is visible on receiveBuffer straight after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            state_q   <= BUF_EMPTY;
            overrun_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    assign receiveBuffer   = hold_q;
    assign newData         = (state_q == BUF_FULL);
    assign readyForReceive = (state_q != BUF_FULL);
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_comms_receiver.sv
// Bench for comms_receiver: randomized and directed frames checked against a bit-queue model.
// Build with COMMS_RX_TIMEOUT_EN defined to exercise the idle-abort path.
module tb_comms_receiver;
    import comms_pkg::*;

    localparam int W = COMMS_FRAME_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         clkIn;
    logic         dataIn;
    logic         dataAck;
    logic [W-1:0] receiveBuffer;
    logic         newData;
    logic         readyForReceive;
    logic         overrun;
    logic         frameError;

    int vectors     = 0;
    int miscompares = 0;
    int ferr_seen   = 0;

    // Reference model: received bits queue up; a full queue is one frame in arrival order.
    bit           m_bits[$];
    logic [W-1:0] m_buf;
    bit           m_new;
    bit           m_ovr;

    comms_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .clkIn          (clkIn),
        .dataIn         (dataIn),
        .dataAck        (dataAck),
        .receiveBuffer  (receiveBuffer),
        .newData        (newData),
        .readyForReceive(readyForReceive),
        .overrun        (overrun),
        .frameError     (frameError)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frameError === 1'b1) ferr_seen++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_reset();
        m_bits.delete();
        m_buf = '0;
        m_new = 1'b0;
        m_ovr = 1'b0;
    endfunction

    function automatic void model_bit(input bit b, input bit ack_now);
        logic [W-1:0] f;
        m_bits.push_back(b);
        if (m_bits.size() == W) begin
            for (int i = 0; i < W; i++) f[i] = m_bits[i];
            m_bits.delete();
            if (!m_new) begin
                m_buf = f;
                m_new = 1'b1;
            end else if (ack_now) begin
                m_buf = f;
            end else begin
                m_ovr = 1'b1;
            end
        end
    endfunction

    function automatic logic [W-1:0] rand_frame();
        logic [W-1:0] f;
        for (int w = 0; w < W / 32; w++) f[w*32 +: 32] = $urandom();
        return f;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".receiveBuffer"}, receiveBuffer, m_buf);
        check({tag, ".newData"}, newData, m_new);
        check({tag, ".readyForReceive"}, readyForReceive, !m_new);
        check({tag, ".overrun"}, overrun, m_ovr);
    endtask

    // One link bit: clkIn low for half clks with data set up, then high for half clks.
    // On a frame-completing bit, dataAck can be pulsed in exactly the frameDone cycle.
    task automatic send_bit(input bit b, input int half, input bit ack_at_done);
        bit completes;
        completes = (m_bits.size() == W - 1);
        clkIn  = 1'b0;
        dataIn = b;
        wait_clks(half);
        clkIn = 1'b1;
        wait_clks(2);
        if (completes) begin
            check("preload.newData", newData, m_new);
            dataAck = ack_at_done;
        end
        wait_clks(1);
        dataAck = 1'b0;
        model_bit(b, ack_at_done);
        if (completes) check_outputs("frame");
        wait_clks(half - 3);
    endtask

    task automatic send_frame(input logic [W-1:0] f, input int half, input bit ack_at_done);
        for (int i = 0; i < W; i++) send_bit(f[i], half, ack_at_done);
    endtask

    task automatic pulse_ack();
        dataAck = 1'b1;
        wait_clks(1);
        dataAck = 1'b0;
        m_new = 1'b0;
        check("ack.newData", newData, m_new);
        check("ack.readyForReceive", readyForReceive, !m_new);
    endtask

    task automatic do_reset(input int hold_after);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        model_reset();
        wait_clks(hold_after);
        check_outputs("reset");
        check("reset.frameError", frameError, 1'b0);
    endtask

    initial begin
        logic [W-1:0] f;
        int           half;
        int           mode;
        int           ferr_before;
        int           ferr_expected;

        rst     = 1'b1;
        clkIn   = 1'b0;
        dataIn  = 1'b0;
        dataAck = 1'b0;
        model_reset();
        wait_clks(1);
        do_reset(1);

        // Single ones at both frame ends: bit ordering and newData latency.
        f = '0;
        f[0] = 1'b1;
        f[W-1] = 1'b1;
        send_frame(f, 4, 1'b0);
        check("t1.exact", receiveBuffer, f);

        // Second frame with no acknowledge is dropped.
        f = {32{8'hA5}};
        send_frame(f, 4, 1'b0);
        check("t2.overrun", overrun, 1'b1);

        // Acknowledge coinciding with frameDone loads the new frame.
        f = {32{8'h3C}};
        send_frame(f, 3, 1'b1);
        check("t3.exact", receiveBuffer, f);

        pulse_ack();
        pulse_ack();

        for (int k = 0; k < 6; k++) begin
            mode = $urandom_range(0, 2);
            half = $urandom_range(3, 5);
            f    = rand_frame();
            if (mode == 0) pulse_ack();
            send_frame(f, half, mode == 1);
        end

        // Reset mid-frame, then all ones must arrive without residue.
        f = rand_frame();
        for (int i = 0; i < 100; i++) send_bit(f[i], 4, 1'b0);
        do_reset(1);
        f = '1;
        send_frame(f, 4, 1'b0);
        check("t4.exact", receiveBuffer, f);

        // Partial frame followed by a long idle.
        pulse_ack();
        f = rand_frame();
        for (int i = 0; i < 40; i++) send_bit(f[i], 4, 1'b0);
        clkIn = 1'b0;
        ferr_before = ferr_seen;
        wait_clks(70);
`ifdef COMMS_RX_TIMEOUT_EN
        m_bits.delete();
        ferr_expected = 1;
`else
        ferr_expected = 0;
`endif
        check("t5.frameError_pulses", ferr_seen - ferr_before, ferr_expected);
        f = {64{4'h5}};
        send_frame(f, 4, 1'b0);
`ifdef COMMS_RX_TIMEOUT_EN
        check("t5.exact", receiveBuffer, f);
`endif

        // clkIn high across reset release must not count as an edge.
        clkIn = 1'b1;
        wait_clks(2);
        do_reset(10);
        f = rand_frame();
        send_frame(f, 5, 1'b0);
        check("t6.exact", receiveBuffer, f);
        check("t6.newData", newData, 1'b1);
        check("frameError_total", ferr_seen, ferr_expected);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
